sr_capture: RTL and testbench
=============================

SR_CAPTURE -- requirements
Module: sr_capture

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, FIFO word width (legal >= 32).
REQ-002 SHALL have parameter CAPTURE_WORDS, default 1, number of readback data words per frame (legal 1..16).
REQ-003 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth for SR inputs (legal >= 2).
REQ-004 SHALL have ports:
- clock  in  1  sole clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  arms capture of the next frame.
- sr_ck1  in  1  SR phase-1 clock, asynchronous.
- sr_ck2  in  1  SR phase-2 clock, asynchronous.
- sr_ld  in  1  SR load strobe, asynchronous.
- sr_sout  in  1  SR serial readback, asynchronous.
- data_out_fifo_data  out  DATA_WIDTH  FIFO write data.
- data_out_fifo_full  in  1  FIFO full.
- data_out_fifo_clock  out  1  equals clock.
- data_out_fifo_wr_en  out  1  FIFO write strobe.
- busy  out  1  state != IDLE.
- overflow  out  1  sticky frame-collision flag.
REQ-005 SHALL use one clock (clock); reset is synchronous and active-high.

Function
REQ-006 SHALL pass sr_ck1, sr_ck2, sr_ld and sr_sout through SYNC_STAGES flops, then one edge-detect flop; all four see identical delay; no SR signal is used as a clock.
REQ-007 SHALL, on each ck1 falling edge, latch synced sout into a reference bit.
REQ-008 SHALL, on each ck2 falling edge in CAPTURE, shift synced sout into an N = DATA_WIDTH*CAPTURE_WORDS bit register at LSB, increment a 16-bit bit counter saturating at 0xFFFF, and increment an 8-bit error counter (saturating at 0xFF) if sout differs from the reference bit.
REQ-009 SHALL, when ck1 and ck2 falling edges coincide, compare against the old reference bit, then update it.
REQ-010 SHALL implement states IDLE, CAPTURE, HEADER, DATA.
REQ-011 IDLE: clear shift register and counters; ck2 fall with enable=1 -> CAPTURE, and that bit is captured as bit 1.
REQ-012 CAPTURE: ld rising edge -> HEADER; a ck2 fall in the same cycle is shifted in first; enable deassertion does not abort the frame.
REQ-013 ld rising edge in IDLE SHALL be ignored; no FIFO write.
REQ-014 HEADER: header word = bits[31:24] 0xA5, [23:16] error count, [15:0] bit count, upper bits zero; DATA: word k (k=0 first) = shift register bits [N-1-k*DATA_WIDTH -: DATA_WIDTH], oldest data first; bits never filled read zero.
REQ-015 SHALL write one word per cycle: when state is HEADER/DATA and data_out_fifo_full=0, the next cycle presents word and wr_en=1 for exactly one cycle; full=1 holds wr_en=0 and the word pending, no data lost.
REQ-016 DATA -> IDLE after word CAPTURE_WORDS-1 is written; frame = 1+CAPTURE_WORDS writes.
REQ-017 ck2 falling edge in HEADER or DATA SHALL be ignored for capture and set overflow=1 (sticky until reset); output words unchanged.
REQ-018 data_out_fifo_data SHALL hold last written value when wr_en=0.

Reset
REQ-019 reset SHALL force state IDLE, wr_en=0, data_out_fifo_data=0, busy=0, overflow=0, counters/shift register/reference/sync/edge flops 0.
REQ-020 reset mid-frame SHALL discard partial capture; no further writes from that frame.

Structure
REQ-021 Package sr_capture_pkg SHALL hold state enum, HEADER_MARKER=8'hA5, counter widths.
REQ-022 Sub-module sr_edge_sync (parametrised synchronizer plus rise/fall pulse outputs) SHALL be instantiated per SR input.

Verification
REQ-023 DW=64, CW=2: 200 matching bits, ld -> 3 writes: header 0x00000000A500_00C8, then last 128 bits, oldest first.
REQ-024 CW=1: 30 bits then ld -> header bit count 0x001E, data word upper 34 bits zero.
REQ-025 sout differs from ck1 sample on bits 5, 17, 40 of 64 -> header error field 0x03.
REQ-026 full=1 for 10 cycles during HEADER -> wr_en stays 0; after release exactly 2 writes, content intact.
REQ-027 ck2 fall during DATA -> overflow=1, frame words unchanged; reset after 40 bits of next frame -> no writes, overflow=0, next frame counts from 1.

Source files
------------

// File: rtl/sr_capture_pkg.sv
// Shared types and constants for the SR readback capture block.
package sr_capture_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CAPTURE,
      ST_HEADER,
      ST_DATA
   } state_t;

   localparam logic [7:0] HEADER_MARKER = 8'hA5;
   localparam int BIT_CNT_W  = 16;
   localparam int ERR_CNT_W  = 8;
   localparam int WORD_IDX_W = 5;

   // Slot of each SR input in the synchronizer array
   localparam int NUM_SR  = 4;
   localparam int SR_CK1  = 0;
   localparam int SR_CK2  = 1;
   localparam int SR_LD   = 2;
   localparam int SR_SOUT = 3;

   typedef struct packed {
      logic [7:0]           marker;
      logic [ERR_CNT_W-1:0] err_cnt;
      logic [BIT_CNT_W-1:0] bit_cnt;
   } header_t;

endpackage

// File: rtl/sr_edge_sync.sv
// Multi-flop synchronizer for one asynchronous SR line, followed by an edge
// flop that yields single-cycle rise/fall pulses aligned with the synced level.
module sr_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   edge_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         sync_q <= '0;
         edge_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
         edge_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level = sync_q[SYNC_STAGES-1];
   assign rise  = level & ~edge_q;
   assign fall  = ~level & edge_q;

endmodule

// File: rtl/sr_capture.sv
// Captures one SR readback frame (bits shifted on ck2 falls) and streams a
// header word plus CAPTURE_WORDS data words into a FIFO, oldest data first.
module sr_capture
   import sr_capture_pkg::*;
#(
   parameter int DATA_WIDTH    = 64,
   parameter int CAPTURE_WORDS = 1,
   parameter int SYNC_STAGES   = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  sr_ck1,
   input  logic                  sr_ck2,
   input  logic                  sr_ld,
   input  logic                  sr_sout,
   output logic [DATA_WIDTH-1:0] data_out_fifo_data,
   input  logic                  data_out_fifo_full,
   output logic                  data_out_fifo_clock,
   output logic                  data_out_fifo_wr_en,
   output logic                  busy,
   output logic                  overflow
);

   localparam int N = DATA_WIDTH * CAPTURE_WORDS;

   logic [NUM_SR-1:0] sr_in, sr_lvl, sr_rise, sr_fall;

   assign sr_in = {sr_sout, sr_ld, sr_ck2, sr_ck1};

   for (genvar i = 0; i < NUM_SR; i++) begin : g_sync
      sr_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
         .clock (clock),
         .reset (reset),
         .din   (sr_in[i]),
         .level (sr_lvl[i]),
         .rise  (sr_rise[i]),
         .fall  (sr_fall[i])
      );
   end

   logic ck1_fall, ck2_fall, ld_rise, sout;
   assign ck1_fall = sr_fall[SR_CK1];
   assign ck2_fall = sr_fall[SR_CK2];
   assign ld_rise  = sr_rise[SR_LD];
   assign sout     = sr_lvl[SR_SOUT];

   logic unused_sr;
   assign unused_sr = ^{sr_rise[SR_CK1], sr_rise[SR_CK2], sr_fall[SR_LD],
                        sr_rise[SR_SOUT], sr_fall[SR_SOUT],
                        sr_lvl[SR_CK1], sr_lvl[SR_CK2], sr_lvl[SR_LD]};

   state_t                 state;
   logic [N-1:0]           shreg;
   logic [BIT_CNT_W-1:0]   bit_cnt;
   logic [ERR_CNT_W-1:0]   err_cnt;
   logic                   ref_bit;
   logic [WORD_IDX_W-1:0]  word_idx;
   logic [DATA_WIDTH-1:0]  hdr_word;
   logic                   mism;

   assign mism = (sout != ref_bit);

   always_comb begin
      hdr_word       = '0;
      hdr_word[31:0] = header_t'{HEADER_MARKER, err_cnt, bit_cnt};
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state               <= ST_IDLE;
         shreg               <= '0;
         bit_cnt             <= '0;
         err_cnt             <= '0;
         ref_bit             <= 1'b0;
         word_idx            <= '0;
         data_out_fifo_data  <= '0;
         data_out_fifo_wr_en <= 1'b0;
         overflow            <= 1'b0;
      end else begin
         data_out_fifo_wr_en <= 1'b0;
         // Nonblocking update: a coincident ck2 fall still compares against the old reference
         if (ck1_fall) ref_bit <= sout;
         case (state)
            ST_IDLE: begin
               shreg   <= '0;
               bit_cnt <= '0;
               err_cnt <= '0;
               if (ck2_fall && enable) begin
                  state   <= ST_CAPTURE;
                  shreg   <= N'(sout);
                  bit_cnt <= BIT_CNT_W'(1);
                  err_cnt <= ERR_CNT_W'(mism);
               end
            end
            ST_CAPTURE: begin
               if (ck2_fall) begin
                  shreg <= {shreg[N-2:0], sout};
                  if (bit_cnt != '1) bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                  if (mism && err_cnt != '1) err_cnt <= err_cnt + ERR_CNT_W'(1);
               end
               if (ld_rise) state <= ST_HEADER;
            end
            ST_HEADER: begin
               if (!data_out_fifo_full) begin
                  data_out_fifo_data  <= hdr_word;
                  data_out_fifo_wr_en <= 1'b1;
                  word_idx            <= '0;
                  state               <= ST_DATA;
               end
            end
            ST_DATA: begin
               // Oldest word sits at the top; shift it out one word per write
               if (!data_out_fifo_full) begin
                  data_out_fifo_data  <= shreg[N-1 -: DATA_WIDTH];
                  data_out_fifo_wr_en <= 1'b1;
                  shreg               <= shreg << DATA_WIDTH;
                  word_idx            <= word_idx + WORD_IDX_W'(1);
                  if (word_idx == WORD_IDX_W'(CAPTURE_WORDS - 1)) state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
         if (ck2_fall && (state == ST_HEADER || state == ST_DATA)) overflow <= 1'b1;
      end
   end

   assign busy                = (state != ST_IDLE);
   assign data_out_fifo_clock = clock;

endmodule

// File: tb/tb_sr_capture.sv
// Drives two capture instances (one and two data words per frame) from the
// same SR lines and checks every FIFO cycle against a frame-level model.
module tb_sr_capture;

   logic clock, reset, enable, sr_ck1, sr_ck2, sr_ld, sr_sout, full;
   logic [63:0] data2, data1;
   logic wr2, wr1, busy2, busy1, ovf2, ovf1, fclk2, fclk1;

   sr_capture #(.DATA_WIDTH(64), .CAPTURE_WORDS(2), .SYNC_STAGES(2)) u_dut2 (
      .clock(clock), .reset(reset), .enable(enable),
      .sr_ck1(sr_ck1), .sr_ck2(sr_ck2), .sr_ld(sr_ld), .sr_sout(sr_sout),
      .data_out_fifo_data(data2), .data_out_fifo_full(full),
      .data_out_fifo_clock(fclk2), .data_out_fifo_wr_en(wr2),
      .busy(busy2), .overflow(ovf2));

   sr_capture #(.DATA_WIDTH(64), .CAPTURE_WORDS(1), .SYNC_STAGES(2)) u_dut1 (
      .clock(clock), .reset(reset), .enable(enable),
      .sr_ck1(sr_ck1), .sr_ck2(sr_ck2), .sr_ld(sr_ld), .sr_sout(sr_sout),
      .data_out_fifo_data(data1), .data_out_fifo_full(full),
      .data_out_fifo_clock(fclk1), .data_out_fifo_wr_en(wr1),
      .busy(busy1), .overflow(ovf1));

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   int n_chk = 0, n_pass = 0;
   int wr2_cnt = 0, wr1_cnt = 0;

   // Frame-level model: bits of the current frame, oldest first
   bit          m_ref, m_cap, m_ovf;
   bit          m_bits[$];
   int          m_err;
   logic [63:0] exp2[$], exp1[$];
   logic [63:0] f2[3], f1[2];
   logic [63:0] last2 = '0, last1 = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_chk++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %h, want %h", name, act, expv);
   endtask

   function automatic bit draining();
      return (exp2.size() != 0) || (exp1.size() != 0);
   endfunction

   task automatic m_ck2_fall(input bit b);
      if (draining()) m_ovf = 1'b1;
      else if (m_cap || enable) begin
         if (!m_cap) begin
            m_cap = 1'b1;
            m_bits.delete();
            m_err = 0;
         end
         m_bits.push_back(b);
         if (b != m_ref && m_err < 255) m_err++;
      end
   endtask

   task automatic m_ld();
      logic [127:0] r2, r1;
      logic [63:0]  hdr;
      int           len, pos;
      if (m_cap && !draining()) begin
         len = m_bits.size();
         r2 = '0;
         r1 = '0;
         for (int i = 0; i < len; i++) begin
            pos = len - 1 - i;
            if (pos < 128) r2[pos] = m_bits[i];
            if (pos < 64)  r1[pos] = m_bits[i];
         end
         hdr = {32'h0, 8'hA5, 8'(m_err), 16'(len > 65535 ? 65535 : len)};
         f2[0] = hdr; f2[1] = r2[127:64]; f2[2] = r2[63:0];
         f1[0] = hdr; f1[1] = r1[63:0];
         for (int k = 0; k < 3; k++) exp2.push_back(f2[k]);
         for (int k = 0; k < 2; k++) exp1.push_back(f1[k]);
      end
      m_cap = 1'b0;
   endtask

   // Per-cycle output compare for both instances
   always @(negedge clock) begin
      if (!reset) begin
         if (wr2) begin
            wr2_cnt++;
            if (exp2.size() == 0) begin
               n_chk++;
               $display("FAIL dut2_spurious_write: got data %h, want no write", data2);
            end else begin
               last2 = exp2.pop_front();
               chk("dut2_word", data2, last2);
            end
         end else chk("dut2_hold", data2, last2);
         if (wr1) begin
            wr1_cnt++;
            if (exp1.size() == 0) begin
               n_chk++;
               $display("FAIL dut1_spurious_write: got data %h, want no write", data1);
            end else begin
               last1 = exp1.pop_front();
               chk("dut1_word", data1, last1);
            end
         end else chk("dut1_hold", data1, last1);
      end
   end

   task automatic hold(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic send_bit(input bit b, input bit r, input bit with_ld = 1'b0);
      sr_sout = r; sr_ck1 = 1'b1; hold(4);
      sr_ck1 = 1'b0; m_ref = r; hold(4);
      sr_sout = b; sr_ck2 = 1'b1; hold(4);
      sr_ck2 = 1'b0; m_ck2_fall(b);
      if (with_ld) begin
         sr_ld = 1'b1;
         m_ld();
      end
      hold(4);
      if (with_ld) begin
         sr_ld = 1'b0;
         hold(4);
      end
   endtask

   task automatic send_coinc(input bit b);
      sr_sout = b; sr_ck1 = 1'b1; sr_ck2 = 1'b1; hold(4);
      sr_ck1 = 1'b0; sr_ck2 = 1'b0;
      m_ck2_fall(b);
      m_ref = b;
      hold(4);
   endtask

   task automatic pulse_ld();
      sr_ld = 1'b1; m_ld(); hold(4);
      sr_ld = 1'b0; hold(4);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      m_cap = 1'b0; m_bits.delete(); m_err = 0; m_ovf = 1'b0; m_ref = 1'b0;
      exp2.delete(); exp1.delete();
      last2 = '0; last1 = '0;
      hold(3);
      reset = 1'b0;
   endtask

   task automatic wait_drain();
      int t = 0;
      while (draining() && t < 1000) begin
         hold(1);
         t++;
      end
      if (t >= 1000) begin
         n_chk++;
         $display("FAIL drain_timeout: got %0d/%0d words pending, want 0", exp2.size(), exp1.size());
         exp2.delete(); exp1.delete();
      end
      hold(4);
   endtask

   int w2, w1;

   initial begin
      reset = 1'b1; enable = 1'b0; full = 1'b0;
      sr_ck1 = 1'b0; sr_ck2 = 1'b0; sr_ld = 1'b0; sr_sout = 1'b0;
      do_reset();
      hold(1);
      chk("rst_wr2", wr2, 0);   chk("rst_wr1", wr1, 0);
      chk("rst_data2", data2, 0); chk("rst_data1", data1, 0);
      chk("rst_busy2", busy2, 0); chk("rst_busy1", busy1, 0);
      chk("rst_ovf2", ovf2, 0);   chk("rst_ovf1", ovf1, 0);
      @(posedge clock); #1;
      chk("fifo_clock2", fclk2, clock); chk("fifo_clock1", fclk1, clock);
      hold(1);

      // ld in IDLE and ck2 falls without enable produce nothing
      pulse_ld();
      send_bit(1'b1, 1'b1);
      send_bit(1'b0, 1'b0);
      pulse_ld();
      hold(4);
      chk("idle_writes", wr2_cnt + wr1_cnt, 0);
      chk("idle_busy2", busy2, 0);

      // 200 matching bits; enable dropped after the first does not abort
      w2 = wr2_cnt; w1 = wr1_cnt;
      enable = 1'b1;
      send_bit(1'b0, 1'b0);
      enable = 1'b0;
      for (int i = 1; i < 200; i++) send_bit(i[0], i[0]);
      chk("cap_busy2", busy2, 1); chk("cap_busy1", busy1, 1);
      pulse_ld();
      chk("pin_hdr200", f2[0], 64'h0000_0000_A500_00C8);
      chk("pin_w0_200", f2[1], 64'h5555_5555_5555_5555);
      chk("pin_w1_200", f2[2], 64'h5555_5555_5555_5555);
      chk("pin_cw1_200", f1[1], 64'h5555_5555_5555_5555);
      wait_drain();
      chk("f200_writes2", wr2_cnt - w2, 3); chk("f200_writes1", wr1_cnt - w1, 2);
      chk("done_busy2", busy2, 0); chk("done_busy1", busy1, 0);

      // 30 bits: short frame, unfilled bits read zero
      enable = 1'b1;
      for (int i = 0; i < 30; i++) send_bit(1'b1, 1'b1);
      pulse_ld();
      chk("pin_hdr30", f1[0], 64'h0000_0000_A500_001E);
      chk("pin_data30", f1[1], 64'h0000_0000_3FFF_FFFF);
      wait_drain();

      // 64 bits with three reference mismatches
      for (int i = 1; i <= 64; i++)
         send_bit(i[2], (i == 5 || i == 17 || i == 40) ? ~i[2] : i[2]);
      pulse_ld();
      chk("pin_hdr_err3", f2[0], 64'h0000_0000_A503_0040);
      wait_drain();

      // Coincident ck1/ck2 fall uses the old reference; ck2 fall alongside ld is kept
      send_bit(1'b1, 1'b1);
      send_coinc(1'b0);
      send_bit(1'b1, 1'b1, 1'b1);
      chk("pin_hdr_coinc", f1[0], 64'h0000_0000_A501_0003);
      chk("pin_data_coinc", f1[1], 64'h5);
      wait_drain();

      // FIFO full held through HEADER
      for (int i = 0; i < 12; i++) send_bit(i[0] ^ i[2], i[0] ^ i[2]);
      full = 1'b1;
      w2 = wr2_cnt; w1 = wr1_cnt;
      pulse_ld();
      hold(10);
      chk("full_writes2", wr2_cnt - w2, 0); chk("full_writes1", wr1_cnt - w1, 0);
      chk("full_busy2", busy2, 1);
      full = 1'b0;
      wait_drain();
      chk("rel_writes2", wr2_cnt - w2, 3); chk("rel_writes1", wr1_cnt - w1, 2);

      // ck2 fall while in DATA: overflow, words untouched
      for (int i = 0; i < 8; i++) send_bit(i[1], i[1]);
      full = 1'b1;
      pulse_ld();
      hold(2);
      full = 1'b0;
      hold(1);
      full = 1'b1;
      send_bit(1'b1, 1'b0);
      hold(2);
      chk("ovf_set2", ovf2, m_ovf); chk("ovf_set1", ovf1, m_ovf);
      full = 1'b0;
      wait_drain();
      chk("ovf_sticky2", ovf2, m_ovf); chk("ovf_sticky1", ovf1, m_ovf);

      // Reset mid-frame discards it; next frame counts from 1
      w2 = wr2_cnt; w1 = wr1_cnt;
      for (int i = 0; i < 40; i++) send_bit(i[1], i[1]);
      chk("pre_rst_busy2", busy2, 1);
      do_reset();
      hold(8);
      chk("rst_mid_writes", (wr2_cnt - w2) + (wr1_cnt - w1), 0);
      chk("rst_mid_ovf2", ovf2, m_ovf); chk("rst_mid_ovf1", ovf1, m_ovf);
      chk("rst_mid_busy2", busy2, 0);
      for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b1);
      pulse_ld();
      chk("pin_hdr_after_rst", f1[0], 64'h0000_0000_A500_0005);
      wait_drain();
      chk("after_rst_writes", (wr2_cnt - w2) + (wr1_cnt - w1), 5);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
